// File: rtl/eth_pll_rst_seq.sv
// Ethernet PLL reset sequencer: PLL reset pulse, lock wait with timeout/retry, lock
// qualification, and Ethernet-domain reset release. `ETH_PLL_AUTO_RELOCK_EN` selects auto-relock.
module eth_pll_rst_seq #(
   parameter int unsigned PLL_RST_CYCLES     = 16,
   parameter int unsigned LOCK_TIMEOUT       = 65535,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned RETRY_W            = 8
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               pll_locked,
   input  logic               relock_req,
   output logic               pll_rst,
   output logic               eth_rst,
   output logic               ready,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_count
);

   localparam int unsigned RCNT_W = (PLL_RST_CYCLES > 1)     ? $clog2(PLL_RST_CYCLES)     : 1;
   localparam int unsigned TCNT_W = (LOCK_TIMEOUT > 1)       ? $clog2(LOCK_TIMEOUT)       : 1;
   localparam int unsigned SCNT_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

   localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(LOCK_STABLE_CYCLES - 1);

`ifdef ETH_PLL_AUTO_RELOCK_EN
   typedef enum logic [2:0] {ST_PLL_RST, ST_WAIT_LOCK, ST_STABLE, ST_RUN} state_t;
`else
   typedef enum logic [2:0] {ST_PLL_RST, ST_WAIT_LOCK, ST_STABLE, ST_RUN, ST_FAULT} state_t;
`endif

   state_t               state_q, state_d;
   logic                 meta_q, lock_s_q;
   logic [RCNT_W-1:0]    rcnt_q, rcnt_d;
   logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
   logic [SCNT_W-1:0]    scnt_q, scnt_d;
   logic                 lock_lost_q, lock_lost_d;
   logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;
   logic                 pll_rst_q, eth_rst_q, ready_q;

   assign retry_inc = (&retry_q) ? retry_q : retry_q + 1'b1;

   // Counters are zero outside their own state, so clearing on exit equals clearing on entry.
   always_comb begin
      state_d     = state_q;
      rcnt_d      = rcnt_q;
      tcnt_d      = tcnt_q;
      scnt_d      = scnt_q;
      lock_lost_d = lock_lost_q;
      retry_d     = retry_q;
      if (relock_req) begin
         state_d     = ST_PLL_RST;
         rcnt_d      = '0;
         tcnt_d      = '0;
         scnt_d      = '0;
         lock_lost_d = 1'b0;
      end else begin
         case (state_q)
            ST_PLL_RST: begin
               if (rcnt_q == RCNT_LAST) begin
                  state_d = ST_WAIT_LOCK;
                  rcnt_d  = '0;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s_q) begin
                  state_d = ST_STABLE;
                  tcnt_d  = '0;
               end else if (tcnt_q == TCNT_LAST) begin
                  state_d = ST_PLL_RST;
                  tcnt_d  = '0;
                  retry_d = retry_inc;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            ST_STABLE: begin
               if (!lock_s_q) begin
                  state_d     = ST_PLL_RST;
                  scnt_d      = '0;
                  lock_lost_d = 1'b1;
                  retry_d     = retry_inc;
               end else if (scnt_q == SCNT_LAST) begin
                  state_d = ST_RUN;
                  scnt_d  = '0;
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (!lock_s_q) begin
                  lock_lost_d = 1'b1;
`ifdef ETH_PLL_AUTO_RELOCK_EN
                  state_d = ST_PLL_RST;
                  retry_d = retry_inc;
`else
                  state_d = ST_FAULT;
`endif
               end
            end
`ifndef ETH_PLL_AUTO_RELOCK_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default: state_d = ST_PLL_RST;
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         meta_q      <= 1'b0;
         lock_s_q    <= 1'b0;
         state_q     <= ST_PLL_RST;
         rcnt_q      <= '0;
         tcnt_q      <= '0;
         scnt_q      <= '0;
         lock_lost_q <= 1'b0;
         retry_q     <= '0;
         pll_rst_q   <= 1'b1;
         eth_rst_q   <= 1'b1;
         ready_q     <= 1'b0;
      end else begin
         meta_q      <= pll_locked;
         lock_s_q    <= meta_q;
         state_q     <= state_d;
         rcnt_q      <= rcnt_d;
         tcnt_q      <= tcnt_d;
         scnt_q      <= scnt_d;
         lock_lost_q <= lock_lost_d;
         retry_q     <= retry_d;
         pll_rst_q   <= (state_d == ST_PLL_RST);
         eth_rst_q   <= (state_d != ST_RUN);
         ready_q     <= (state_d == ST_RUN);
      end
   end

   assign pll_rst     = pll_rst_q;
   assign eth_rst     = eth_rst_q;
   assign ready       = ready_q;
   assign lock_lost   = lock_lost_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_eth_pll_rst_seq.sv
// Directed bench for eth_pll_rst_seq; cycle 0 is the cycle right after rst is released.
module tb_eth_pll_rst_seq;

   localparam int unsigned PRC = 4;
   localparam int unsigned LT  = 20;
   localparam int unsigned LSC = 8;
   localparam int unsigned RW  = 2;

   logic          refclk = 1'b0;
   logic          rst = 1'b1;
   logic          pll_locked = 1'b0;
   logic          relock_req = 1'b0;
   logic          pll_rst, eth_rst, ready, lock_lost;
   logic [RW-1:0] retry_count;

   int checks = 0;
   int errors = 0;

   eth_pll_rst_seq #(
      .PLL_RST_CYCLES(PRC),
      .LOCK_TIMEOUT(LT),
      .LOCK_STABLE_CYCLES(LSC),
      .RETRY_W(RW)
   ) dut (
      .refclk(refclk),
      .rst(rst),
      .pll_locked(pll_locked),
      .relock_req(relock_req),
      .pll_rst(pll_rst),
      .eth_rst(eth_rst),
      .ready(ready),
      .lock_lost(lock_lost),
      .retry_count(retry_count)
   );

   always #5 refclk = ~refclk;

   task automatic do_reset;
      rst = 1'b1;
      pll_locked = 1'b0;
      relock_req = 1'b0;
      repeat (2) @(posedge refclk);
      #1;
      rst = 1'b0;
   endtask

   task automatic next_cycle;
      @(posedge refclk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #12;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({pll_rst, eth_rst, ready, lock_lost} !== 4'b1100 || retry_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_values pass=%0d got pr/er/rdy/ll=%b%b%b%b rc=%0d exp 1100 rc=0",
                     i, pll_rst, eth_rst, ready, lock_lost, retry_count);
         end
         next_cycle();
      end
   endtask

   task automatic test_nominal;
      logic exp_pr, exp_rdy;
      do_reset();
      for (int c = 0; c <= 25; c++) begin
         if (c == 10) pll_locked = 1'b1;
         exp_pr  = (c <= 3);
         exp_rdy = (c >= 21);
         checks++;
         if (pll_rst !== exp_pr || ready !== exp_rdy || eth_rst !== !exp_rdy) begin
            errors++;
            $display("FAIL nominal cyc=%0d got pr=%b rdy=%b er=%b exp pr=%b rdy=%b er=%b",
                     c, pll_rst, ready, eth_rst, exp_pr, exp_rdy, !exp_rdy);
         end
         next_cycle();
      end
      checks++;
      if (retry_count !== 2'd0 || lock_lost !== 1'b0) begin
         errors++;
         $display("FAIL nominal_status got rc=%0d ll=%b exp rc=0 ll=0", retry_count, lock_lost);
      end
   endtask

   task automatic test_timeout;
      logic       exp_pr;
      logic [1:0] exp_rc;
      do_reset();
      for (int c = 0; c <= 100; c++) begin
         exp_pr = ((c % 24) < 4);
         exp_rc = (c / 24 >= 3) ? 2'd3 : 2'(c / 24);
         checks++;
         if (pll_rst !== exp_pr || retry_count !== exp_rc || eth_rst !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout cyc=%0d got pr=%b rc=%0d er=%b rdy=%b exp pr=%b rc=%0d er=1 rdy=0",
                     c, pll_rst, retry_count, eth_rst, ready, exp_pr, exp_rc);
         end
         next_cycle();
      end
   endtask

   task automatic test_unstable;
      logic       exp_pr, exp_ll;
      logic [1:0] exp_rc;
      do_reset();
      for (int c = 0; c <= 30; c++) begin
         if (c == 10) pll_locked = 1'b1;
         if (c == 15) pll_locked = 1'b0;
         exp_pr = (c <= 3) || (c >= 18 && c <= 21);
         exp_ll = (c >= 18);
         exp_rc = (c >= 18) ? 2'd1 : 2'd0;
         checks++;
         if (pll_rst !== exp_pr || lock_lost !== exp_ll || retry_count !== exp_rc ||
             eth_rst !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL unstable cyc=%0d got pr=%b ll=%b rc=%0d er=%b rdy=%b exp pr=%b ll=%b rc=%0d er=1 rdy=0",
                     c, pll_rst, lock_lost, retry_count, eth_rst, ready, exp_pr, exp_ll, exp_rc);
         end
         next_cycle();
      end
   endtask

   task automatic test_loss_in_run;
      logic       exp_pr, exp_rdy, exp_ll;
      logic [1:0] exp_rc;
      do_reset();
      for (int c = 0; c <= 62; c++) begin
         if (c == 10) pll_locked = 1'b1;
         if (c == 25) pll_locked = 1'b0;
         if (c == 34) pll_locked = 1'b1;
`ifdef ETH_PLL_AUTO_RELOCK_EN
         exp_pr  = (c <= 3) || (c >= 28 && c <= 31);
         exp_rdy = (c >= 21 && c <= 27) || (c >= 45);
         exp_ll  = (c >= 28);
         exp_rc  = (c >= 28) ? 2'd1 : 2'd0;
`else
         relock_req = (c == 46);
         exp_pr  = (c <= 3) || (c >= 47 && c <= 50);
         exp_rdy = (c >= 21 && c <= 27) || (c >= 60);
         exp_ll  = (c >= 28 && c <= 46);
         exp_rc  = 2'd0;
`endif
         checks++;
         if (pll_rst !== exp_pr || ready !== exp_rdy || eth_rst !== !exp_rdy ||
             lock_lost !== exp_ll || retry_count !== exp_rc) begin
            errors++;
            $display("FAIL loss_in_run cyc=%0d got pr=%b rdy=%b er=%b ll=%b rc=%0d exp pr=%b rdy=%b er=%b ll=%b rc=%0d",
                     c, pll_rst, ready, eth_rst, lock_lost, retry_count,
                     exp_pr, exp_rdy, !exp_rdy, exp_ll, exp_rc);
         end
         next_cycle();
      end
      relock_req = 1'b0;
   endtask

   task automatic test_relock_coincident;
      logic exp_pr, exp_rdy;
      do_reset();
      for (int c = 0; c <= 31; c++) begin
         if (c == 10) pll_locked = 1'b1;
         if (c == 25) pll_locked = 1'b0;
         relock_req = (c == 27);
         exp_pr  = (c <= 3) || (c >= 28);
         exp_rdy = (c >= 21 && c <= 27);
         checks++;
         if (pll_rst !== exp_pr || ready !== exp_rdy || lock_lost !== 1'b0 || retry_count !== 2'd0) begin
            errors++;
            $display("FAIL relock_coincident cyc=%0d got pr=%b rdy=%b ll=%b rc=%0d exp pr=%b rdy=%b ll=0 rc=0",
                     c, pll_rst, ready, lock_lost, retry_count, exp_pr, exp_rdy);
         end
         next_cycle();
      end
      relock_req = 1'b0;
   endtask

   task automatic test_async_reset;
      do_reset();
      for (int c = 0; c < 35; c++) begin
         if (c == 30) pll_locked = 1'b1;
         next_cycle();
      end
      checks++;
      if (pll_rst !== 1'b0 || eth_rst !== 1'b1 || ready !== 1'b0 || retry_count !== 2'd1) begin
         errors++;
         $display("FAIL async_pre_state got pr=%b er=%b rdy=%b rc=%0d exp pr=0 er=1 rdy=0 rc=1",
                  pll_rst, eth_rst, ready, retry_count);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({pll_rst, eth_rst, ready, lock_lost} !== 4'b1100 || retry_count !== 2'd0) begin
         errors++;
         $display("FAIL async_reset got pr/er/rdy/ll=%b%b%b%b rc=%0d exp 1100 rc=0",
                  pll_rst, eth_rst, ready, lock_lost, retry_count);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_timeout();
      test_unstable();
      test_loss_in_run();
      test_relock_coincident();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
